mux_nto1_rr: RTL

- Parametrised N-to-1, WIDTH-bit data selector with a registered output stage and a valid/ready handshake.
- Two selection modes:
  - direct: an external select picks the channel, as in the combinational 16:1 datapath mux;
  - round-robin: the block arbitrates fairly among requesting channels.
- Used where multiple producers (register-file read ports, forwarding sources, bus masters) share one downstream consumer.

---
 rtl/mux_nto1_rr_if.sv | 28 ++
 rtl/mux_nto1_rr.sv | 108 ++++++++++
 2 files changed

// File: rtl/mux_nto1_rr_if.sv
// Channel, handshake and output bus of the N-to-1 registered selector.
// The master side drives requests, data, select and out_ready; the slave side is the mux.
interface mux_nto1_rr_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SELW  = 4
);
  localparam int unsigned N = 1 << SELW;

  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [N-1:0]         req;
  logic [N*WIDTH-1:0]   d;
  logic [N-1:0]         grant;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     y;
  logic [SELW-1:0]      y_idx;

  modport master (
    output mode, sel, req, d, out_ready,
    input  grant, out_valid, y, y_idx
  );

  modport slave (
    input  mode, sel, req, d, out_ready,
    output grant, out_valid, y, y_idx
  );
endinterface

// File: rtl/mux_nto1_rr.sv
// N-to-1 selector with registered output, valid/ready handshake, direct or round-robin selection.
// Optional MUX_LOCK_EN adds a lock input that holds round-robin priority on the granted channel.
module mux_nto1_rr #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SELW  = 4
) (
  input logic          clk,
  input logic          reset,
`ifdef MUX_LOCK_EN
  input logic          lock,
`endif
  mux_nto1_rr_if.slave bus
);
  localparam int unsigned N = 1 << SELW;

  logic [WIDTH-1:0] r_y;
  logic [SELW-1:0]  r_y_idx;
  logic             r_out_valid;
  logic [SELW-1:0]  r_ptr;

  logic [WIDTH-1:0] w_ch [N];
  logic             w_load_ok;
  logic             w_rr_found;
  logic [SELW-1:0]  w_rr_idx;
  logic [SELW-1:0]  w_scan;
  logic [SELW-1:0]  w_cand;
  logic             w_cand_req;
  logic             w_capture;
  logic [N-1:0]     w_grant;
  logic [SELW-1:0]  w_ptr_next;
  logic             w_hold_ptr;

  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      w_ch[i] = bus.d[i*WIDTH +: WIDTH];
    end
  end

  assign w_load_ok = !r_out_valid || bus.out_ready;

  // Scan from the far end back toward ptr so the closest requester after ptr wins.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    w_scan     = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      w_scan = r_ptr + SELW'(k);
      if (bus.req[w_scan]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = w_scan;
      end
    end
  end

  always_comb begin
    w_cand     = bus.sel;
    w_cand_req = bus.req[bus.sel];
    if (bus.mode) begin
      w_cand     = w_rr_idx;
      w_cand_req = w_rr_found;
    end
  end

  assign w_capture = !reset && w_load_ok && w_cand_req;
  assign w_grant   = w_capture ? (N'(1) << w_cand) : '0;

`ifdef MUX_LOCK_EN
  assign w_hold_ptr = lock;
`else
  assign w_hold_ptr = 1'b0;
`endif

  always_comb begin
    w_ptr_next = r_ptr;
    if (w_capture && bus.mode) begin
      w_ptr_next = w_hold_ptr ? w_cand : w_cand + SELW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_y         <= '0;
      r_y_idx     <= '0;
      r_out_valid <= 1'b0;
      r_ptr       <= '0;
    end else begin
      r_ptr <= w_ptr_next;
      if (w_capture) begin
        r_y         <= w_ch[w_cand];
        r_y_idx     <= w_cand;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.grant     = w_grant;
  assign bus.out_valid = r_out_valid;
  assign bus.y         = r_y;
  assign bus.y_idx     = r_y_idx;

  a_grant_onehot: assert property (@(posedge clk) $onehot0(w_grant));
  a_grant_gated:  assert property (@(posedge clk) !w_load_ok |-> (w_grant == '0));
  a_hold_stable:  assert property (@(posedge clk) disable iff (reset)
                                   (r_out_valid && !bus.out_ready) |=> $stable(r_y));

endmodule
